ddc_iq_packer: RTL

// Parametrised I/Q sample packer that sits between the DDC channel filters and the dc FIFO feeding the FX2LP sender.

---
 rtl/ddc_iq_packer_if.sv | 24 ++
 rtl/ddc_iq_packer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ddc_iq_packer_if.sv
// Sample-set input bus and packed-word output stream of the DDC I/Q packer.
// Output handshake: out_data/out_sop move when out_valid & out_ready on a rising clk; out_valid never waits on out_ready.
interface ddc_iq_packer_if #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 16
);
  logic [NUM_CH*SAMPLE_WIDTH-1:0] in_i;
  logic [NUM_CH*SAMPLE_WIDTH-1:0] in_q;
  logic                           in_valid;
  logic [31:0]                    out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_sop;

  modport master (
    input  in_i, in_q, in_valid, out_ready,
    output out_data, out_valid, out_sop
  );

  modport slave (
    output in_i, in_q, in_valid, out_ready,
    input  out_data, out_valid, out_sop
  );
endinterface

// File: rtl/ddc_iq_packer.sv
// Snapshots NUM_CH I/Q pairs per strobe, packs them into 32-bit words (16- or 8-bit lanes)
// and queues them in a show-ahead FIFO; whole sets are dropped and counted when they cannot fit.
module ddc_iq_packer #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          mode,
  input  logic                          clear_ovf,
  ddc_iq_packer_if.master               bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count,
  output logic                          dbg_state_o
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int W0 = NUM_CH;
  localparam int W1 = (NUM_CH + 1) / 2;
  localparam int PW = 2 * W1 * SW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   last_q, last_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   si_q, si_d;
  logic [PW-1:0]   sq_q, sq_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     ovf_q, ovf_d;
  logic [32:0]     mem [FIFO_DEPTH];

  logic [LW-1:0]   need_w;
  logic [LW-1:0]   free_w;
  logic            req, accept, drop;
  logic            wr_en, rd_en, wsop;
  logic [31:0]     wdata;

  // Space is checked against the registered level only, so a same-cycle read never helps a set in.
  assign need_w = mode ? LW'(W1) : LW'(W0);
  assign free_w = LW'(FIFO_DEPTH) - level_q;
  assign req    = bus.in_valid & enable;
  assign accept = req & (state_q == IDLE) & (free_w >= need_w);
  assign drop   = req & ~accept;

  // Shadows are padded to an even channel count with zeros, which gives the zero upper half for odd NUM_CH.
  always_comb begin
    wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!mode_q && idx_q == CW'(k)) begin
        wdata = {sq_q[k*SW+SW-1 -: 16], si_q[k*SW+SW-1 -: 16]};
      end
    end
    for (int k = 0; k < W1; k++) begin
      if (mode_q && idx_q == CW'(k)) begin
        wdata = {sq_q[(2*k+1)*SW+SW-1 -: 8], si_q[(2*k+1)*SW+SW-1 -: 8],
                 sq_q[(2*k)*SW+SW-1 -: 8],   si_q[(2*k)*SW+SW-1 -: 8]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    mode_d  = mode_q;
    si_d    = si_q;
    sq_d    = sq_q;
    wr_en   = 1'b0;
    wsop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
          idx_d   = '0;
          mode_d  = mode;
          last_d  = mode ? CW'(W1 - 1) : CW'(W0 - 1);
          si_d    = PW'(bus.in_i);
          sq_d    = PW'(bus.in_q);
        end
      end
      EMIT: begin
        wr_en = 1'b1;
        wsop  = (idx_q == '0);
        if (idx_q == last_q) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = drop ? 16'd1 : 16'd0;
    end else if (drop && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  assign bus.out_valid = (level_q != '0);
  assign rd_en         = bus.out_valid & bus.out_ready;
  assign level_d       = level_q + LW'(wr_en) - LW'(rd_en);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr_q][31:0] : 32'd0;
  assign bus.out_sop   = bus.out_valid & mem[rd_ptr_q][32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      mode_q   <= 1'b0;
      si_q     <= '0;
      sq_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      si_q     <= si_d;
      sq_q     <= sq_d;
      wr_ptr_q <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q <= rd_ptr_q + AW'(rd_en);
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the level and pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {wsop, wdata};
    end
  end

  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign dbg_state_o    = state_q;

endmodule
